axi_b_resp_router: RTL

Parametrised AXI write-response (B) channel router between N slave ports and M master ports of the interconnect. It arbitrates round-robin among slaves presenting BVALID and registers the selected response in a one-entry output stage. The response is delivered to the master decoded from the upper bits of the extended ID. Responses whose master index is unmapped are consumed and dropped.

---
 rtl/axi_b_resp_router.sv | 131 +++++++++++++
 1 files changed

// File: rtl/axi_b_resp_router.sv
// AXI B-channel router: round-robin over slave BVALIDs into a one-entry stage, one cycle latency, drop counter under AXI_B_DROP_CNT_EN.
// Backpressure: slave BREADY is withheld while the stage holds a response its master has not accepted.
module axi_b_resp_router #(
  parameter int SLV_NUM   = 7,
  parameter int MST_NUM   = 3,
  parameter int ID_BITS   = 4,
  parameter int MST_BITS  = 4,
  parameter int RESP_BITS = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SLV_NUM*(MST_BITS+ID_BITS)-1:0] ids_s_i,
  input  logic [SLV_NUM*RESP_BITS-1:0]    resp_s_i,
  input  logic [SLV_NUM-1:0]              valid_s_i,
  output logic [SLV_NUM-1:0]              ready_s_o,
  output logic [MST_NUM*ID_BITS-1:0]      id_m_o,
  output logic [MST_NUM*RESP_BITS-1:0]    resp_m_o,
  output logic [MST_NUM-1:0]              valid_m_o,
  input  logic [MST_NUM-1:0]              ready_m_i
`ifdef AXI_B_DROP_CNT_EN
  ,
  output logic [7:0]                      drop_cnt_o
`endif
);

  localparam int IDS   = MST_BITS + ID_BITS;
  localparam int PTR_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;

  logic [IDS-1:0]       out_ids_q, out_ids_d;
  logic [RESP_BITS-1:0] out_resp_q, out_resp_d;
  logic                 out_vld_q, out_vld_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [MST_BITS-1:0]  out_mst;
  logic                 drain, free, any_vld, hs, mapped;
  logic [PTR_W-1:0]     gnt;
  logic [IDS-1:0]       gnt_ids;
  logic [RESP_BITS-1:0] gnt_resp;

  assign out_mst = out_ids_q[IDS-1:ID_BITS];

  always_comb begin
    drain     = 1'b0;
    valid_m_o = '0;
    for (int m = 0; m < MST_NUM; m++) begin
      if (out_mst == MST_BITS'(m)) begin
        valid_m_o[m] = out_vld_q;
        drain        = out_vld_q & ready_m_i[m];
      end
    end
  end

  assign free = !out_vld_q | drain;

  // Search begins at rr_ptr and wraps; no lock needed since BVALID is sticky.
  always_comb begin
    any_vld  = 1'b0;
    gnt      = '0;
    gnt_ids  = '0;
    gnt_resp = '0;
    for (int i = 0; i < SLV_NUM; i++) begin
      int idx;
      idx = int'(rr_ptr_q) + i;
      if (idx >= SLV_NUM) idx = idx - SLV_NUM;
      if (!any_vld && valid_s_i[idx]) begin
        any_vld  = 1'b1;
        gnt      = PTR_W'(idx);
        gnt_ids  = ids_s_i[idx*IDS +: IDS];
        gnt_resp = resp_s_i[idx*RESP_BITS +: RESP_BITS];
      end
    end
  end

  assign hs     = any_vld & free & rst;
  assign mapped = int'(gnt_ids[IDS-1:ID_BITS]) < MST_NUM;

  always_comb begin
    ready_s_o = '0;
    if (hs) ready_s_o[gnt] = 1'b1;
  end

  always_comb begin
    out_ids_d  = out_ids_q;
    out_resp_d = out_resp_q;
    out_vld_d  = out_vld_q;
    rr_ptr_d   = rr_ptr_q;
    if (drain) out_vld_d = 1'b0;
    if (hs) begin
      rr_ptr_d = (int'(gnt) == SLV_NUM - 1) ? '0 : gnt + PTR_W'(1);
      if (mapped) begin
        out_ids_d  = gnt_ids;
        out_resp_d = gnt_resp;
        out_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_ids_q  <= '0;
      out_resp_q <= '0;
      out_vld_q  <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      out_ids_q  <= out_ids_d;
      out_resp_q <= out_resp_d;
      out_vld_q  <= out_vld_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign id_m_o   = {MST_NUM{out_ids_q[ID_BITS-1:0]}};
  assign resp_m_o = {MST_NUM{out_resp_q}};

`ifdef AXI_B_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (hs && !mapped && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
